// File: rtl/sdp_x_mul_cfg_triosy_sched.sv
// Issues one round-robin lz pulse per selected config resource after each layer,
// holding the core off until the sequence completes; tracks bawt and sticky errors.
module sdp_x_mul_cfg_triosy_sched #(
  parameter int NUM_RSC   = 8,
  parameter int TIMEOUT_W = 8
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               layer_done,
  input  logic [NUM_RSC-1:0] rsc_mask,
  input  logic               triosy_hold,
  input  logic               err_clr,
  output logic               core_wen,
  output logic               busy,
  output logic [NUM_RSC-1:0] triosy_lz,
  output logic [NUM_RSC-1:0] rsc_bawt,
  output logic               cfg_done,
  output logic               err_overrun,
  output logic               err_timeout
);

  localparam int PW = (NUM_RSC > 1) ? $clog2(NUM_RSC) : 1;
  localparam int SW = PW + 1;
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_RSC-1:0]   pending;
  logic [NUM_RSC-1:0]   sel_oh;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        sel_inc;
  logic [SW-1:0]        scan;
  logic                 found;
  logic                 last;
  logic                 issue;
  logic                 accept;
  logic                 hold_active;
  logic                 tmo_hit;
  logic [TIMEOUT_W-1:0] hold_cnt;

  // Cyclic scan of pending starting at rr_ptr; scan index wraps at NUM_RSC.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < NUM_RSC; i++) begin
      scan = {1'b0, rr_ptr} + SW'(i);
      if (scan >= SW'(NUM_RSC)) scan = scan - SW'(NUM_RSC);
      if (!found && pending[scan[PW-1:0]]) begin
        found = 1'b1;
        sel   = scan[PW-1:0];
      end
    end
  end

  assign sel_oh  = NUM_RSC'(1) << sel;
  assign sel_inc = (sel == PW'(NUM_RSC - 1)) ? '0 : sel + 1'b1;
  assign last    = (pending & ~sel_oh) == '0;
  assign issue   = (state == ISSUE) && !triosy_hold && found;
  assign accept  = (state == IDLE) && layer_done;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (layer_done) state_nxt = (|rsc_mask) ? ISSUE : DONE;
      ISSUE:   if (issue && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign core_wen = (state == IDLE);
  assign busy     = ~core_wen;
  assign cfg_done = (state == DONE);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      triosy_lz <= '0;
      rsc_bawt  <= '0;
    end else begin
      triosy_lz <= issue ? sel_oh : '0;
      if (accept) begin
        pending  <= rsc_mask;
        rsc_bawt <= '0;
      end else if (issue) begin
        pending  <= pending & ~sel_oh;
        rsc_bawt <= rsc_bawt | sel_oh;
        rr_ptr   <= sel_inc;
      end
    end
  end

  // Timeout flags only on the transition into all-ones, so a clear while still held sticks.
  assign hold_active = (state == ISSUE) && triosy_hold;
  assign tmo_hit     = hold_active && (hold_cnt == CNT_MAX - 1'b1);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      hold_cnt    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (!hold_active)          hold_cnt <= '0;
      else if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;

      if (tmo_hit)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      if (layer_done && (state != IDLE)) err_overrun <= 1'b1;
      else if (err_clr)                  err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdp_x_mul_cfg_triosy_sched.sv
// Bench for sdp_x_mul_cfg_triosy_sched: vector table, directed corner sequences,
// and randomized layers checked against a transaction-level order/timing model.
module tb_sdp_x_mul_cfg_triosy_sched;

  logic       clk;
  logic       rst;
  logic       layer_done;
  logic [7:0] rsc_mask;
  logic       triosy_hold;
  logic       err_clr;
  logic       core_wen;
  logic       busy;
  logic [7:0] triosy_lz;
  logic [7:0] rsc_bawt;
  logic       cfg_done;
  logic       err_overrun;
  logic       err_timeout;

  sdp_x_mul_cfg_triosy_sched #(.NUM_RSC(8), .TIMEOUT_W(4)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .layer_done    (layer_done),
    .rsc_mask      (rsc_mask),
    .triosy_hold   (triosy_hold),
    .err_clr       (err_clr),
    .core_wen      (core_wen),
    .busy          (busy),
    .triosy_lz     (triosy_lz),
    .rsc_bawt      (rsc_bawt),
    .cfg_done      (cfg_done),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: round-robin pointer and sticky errors
  int         m_ptr = 0;
  bit         m_ovr = 0;
  bit         m_tmo = 0;
  logic [31:0] obs_code;
  int          obs_len;

  typedef struct {
    logic       ld;
    logic [7:0] mask;
    logic       hold;
    logic       clr;
    logic       wen;
    logic [7:0] lz;
    logic       done;
    logic [7:0] bawt;
    logic       ovr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    layer_done  = 1'b0;
    rsc_mask    = 8'h00;
    triosy_hold = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst   = 1'b0;
    m_ptr = 0;
    m_ovr = 0;
    m_tmo = 0;
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_ovr = 0;
    m_tmo = 0;
    chk("clr_ovr", err_overrun, 0);
    chk("clr_tmo", err_timeout, 0);
  endtask

  // One layer: expected order is the mask bits in cyclic order from the pointer;
  // every non-hold ISSUE cycle emits the next one.
  task automatic run_layer(input logic [7:0] mask, input int hs, input int hl,
                           input bit rnd, input bit ovr);
    int q[$];
    int t, run, idx, last_idx;
    bit h, od, clr;
    logic [7:0] eb, el;
    for (int j = 0; j < 8; j++) begin
      idx = (m_ptr + j) % 8;
      if (mask[idx]) q.push_back(idx);
    end
    obs_code = 0; eb = 8'h00; run = 0; last_idx = -1;
    layer_done = 1'b1; rsc_mask = mask; triosy_hold = 1'b0; err_clr = 1'b0;
    step();
    layer_done = 1'b0; rsc_mask = 8'($urandom);
    chk("start_wen", core_wen, 0);
    chk("start_busy", busy, 1);
    chk("start_lz", triosy_lz, 0);
    chk("start_done", cfg_done, mask == 8'h00);
    chk("start_bawt", rsc_bawt, 0);
    t = 0;
    while (q.size() > 0 && t < 200) begin
      h   = (t >= hs && t < hs + hl) || (rnd && $urandom_range(3) == 0);
      od  = ovr && t == 1;
      clr = od && $urandom_range(1) == 1;
      triosy_hold = h; layer_done = od; rsc_mask = 8'($urandom); err_clr = clr;
      step();
      t++;
      if (clr) begin m_ovr = 0; m_tmo = 0; end
      if (od) m_ovr = 1;
      el = 8'h00;
      if (h) begin
        run++;
        if (run == 15) m_tmo = 1;
      end else begin
        run = 0;
        idx = q.pop_front();
        last_idx = idx;
        el = 8'(1 << idx);
        eb = eb | el;
        obs_code = (obs_code << 4) | 32'(idx);
      end
      chk("seq_lz", triosy_lz, el);
      chk("seq_done", cfg_done, !h && q.size() == 0);
      chk("seq_wen", core_wen, 0);
      chk("seq_bawt", rsc_bawt, eb);
      chk("seq_ovr", err_overrun, m_ovr);
      chk("seq_tmo", err_timeout, m_tmo);
    end
    obs_len = t;
    chk("layer_bound", q.size(), 0);
    idle_inputs();
    step();
    chk("end_wen", core_wen, 1);
    chk("end_done", cfg_done, 0);
    chk("end_lz", triosy_lz, 0);
    chk("end_bawt", rsc_bawt, eb);
    if (last_idx >= 0) m_ptr = (last_idx + 1) % 8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 8'h05, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h05, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 8'h03, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h03, 1'b0};

    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_wen", core_wen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lz", triosy_lz, 0);
    chk("rst_bawt", rsc_bawt, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_ovr", err_overrun, 0);
    chk("rst_tmo", err_timeout, 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      layer_done = tbl[i].ld; rsc_mask = tbl[i].mask;
      triosy_hold = tbl[i].hold; err_clr = tbl[i].clr;
      step();
      chk("tbl_wen", core_wen, tbl[i].wen);
      chk("tbl_busy", busy, !tbl[i].wen);
      chk("tbl_lz", triosy_lz, tbl[i].lz);
      chk("tbl_done", cfg_done, tbl[i].done);
      chk("tbl_bawt", rsc_bawt, tbl[i].bawt);
      chk("tbl_ovr", err_overrun, tbl[i].ovr);
    end
    idle_inputs();
    m_ptr = 2;

    // round robin across layers, then a held gap mid-sequence
    do_reset();
    run_layer(8'hFF, 0, 0, 0, 0);
    chk("rr_ff_order", obs_code, 32'h01234567);
    run_layer(8'h03, 0, 0, 0, 0);
    chk("rr_03_order", obs_code, 32'h01);
    run_layer(8'h83, 1, 3, 0, 0);
    chk("rr_83_order", obs_code, 32'h701);
    chk("rr_83_len", obs_len, 6);

    // layer_done during DONE is an overrun and is not accepted
    layer_done = 1'b1; rsc_mask = 8'h00;
    step();
    chk("dn_done", cfg_done, 1);
    layer_done = 1'b1; rsc_mask = 8'h10;
    step();
    chk("dn_wen", core_wen, 1);
    chk("dn_ovr", err_overrun, 1);
    idle_inputs();
    step();
    chk("dn_idle_wen", core_wen, 1);
    chk("dn_idle_lz", triosy_lz, 0);
    m_ovr = 1;
    do_clr();

    // hold timeout after 15 consecutive held cycles, then resume
    do_reset();
    run_layer(8'h1F, 1, 15, 0, 0);
    chk("tmo_order", obs_code, 32'h01234);
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_len", obs_len, 20);
    do_clr();

    // reset in the middle of a sequence
    do_reset();
    layer_done = 1'b1; rsc_mask = 8'h1F;
    step();
    idle_inputs();
    step();
    chk("mid_lz0", triosy_lz, 8'h01);
    step();
    chk("mid_lz1", triosy_lz, 8'h02);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wen", core_wen, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lz", triosy_lz, 0);
    chk("mid_rst_bawt", rsc_bawt, 0);
    chk("mid_rst_done", cfg_done, 0);
    step();
    rst = 1'b0;
    m_ptr = 0; m_ovr = 0; m_tmo = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_lz", triosy_lz, 0);
      chk("post_rst_done", cfg_done, 0);
    end
    run_layer(8'h81, 0, 0, 0, 0);
    chk("post_rst_order", obs_code, 32'h07);

    // randomized layers against the model
    for (int r = 0; r < 40; r++) begin
      logic [7:0] m;
      m = 8'($urandom);
      if ($urandom_range(5) == 0) m = 8'h00;
      run_layer(m, 0, 0, 1, $urandom_range(3) == 0);
      if ($urandom_range(3) == 0) do_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
